// File: rtl/ext_stream.sv
// ext_stream: valid/ready sign/zero extender with a two-entry output buffer
// and saturating accept / ones-filled statistics counters.
module ext_stream #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_fill,
   output logic [CNT_WIDTH-1:0] acc_count,
   output logic [CNT_WIDTH-1:0] neg_count
);

   localparam int EXT_W = OUT_WIDTH - IN_WIDTH;

   // Refuse to build a configuration that would leave no room for a fill bit.
   generate
      if (OUT_WIDTH < IN_WIDTH + 1) begin : g_bad_width
         $error("ext_stream: OUT_WIDTH must be at least IN_WIDTH+1");
      end
   endgenerate

   logic [OUT_WIDTH-1:0] mem_data [2];
   logic [1:0]           mem_fill;
   logic                 rd_ptr;
   logic                 wr_ptr;
   logic [1:0]           occ;
   logic                 push;
   logic                 pop;
   logic                 fill_new;

   // Handshake decode; ready/valid come only from registered occupancy.
   assign in_ready  = (occ != 2'd2);
   assign out_valid = (occ != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign fill_new  = in_mode & in_data[IN_WIDTH-1];
   assign out_data  = mem_data[rd_ptr];
   assign out_fill  = mem_fill[rd_ptr];

   // Storage: extension happens once, at accept time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_data[0] <= '0;
         mem_data[1] <= '0;
         mem_fill    <= '0;
      end else if (push) begin
         mem_data[wr_ptr] <= {{EXT_W{fill_new}}, in_data};
         mem_fill[wr_ptr] <= fill_new;
      end
   end

   // Pointers and occupancy; a push and pop together leave occupancy unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Saturating statistics counters; they stick at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_count <= '0;
         neg_count <= '0;
      end else if (push) begin
         if (acc_count != '1)             acc_count <= acc_count + 1'b1;
         if (fill_new && neg_count != '1) neg_count <= neg_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_ext_stream.sv
// tb_ext_stream: directed checks of ext_stream at default widths, a 16->32
// instance and a 2-bit-counter instance.
module tb_ext_stream;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Instance a: defaults
   logic        a_in_valid = 0, a_in_mode = 0, a_out_ready = 0;
   logic [7:0]  a_in_data = 0;
   logic        a_in_ready, a_out_valid, a_out_fill;
   logic [15:0] a_out_data, a_acc, a_neg;

   // Instance b: 16 -> 32
   logic        b_in_valid = 0, b_in_mode = 0, b_out_ready = 0;
   logic [15:0] b_in_data = 0;
   logic        b_in_ready, b_out_valid, b_out_fill;
   logic [31:0] b_out_data;
   logic [15:0] b_acc, b_neg;

   // Instance c: 2-bit counters
   logic        c_in_valid = 0, c_in_mode = 0, c_out_ready = 0;
   logic [7:0]  c_in_data = 0;
   logic        c_in_ready, c_out_valid, c_out_fill;
   logic [15:0] c_out_data;
   logic [1:0]  c_acc, c_neg;

   ext_stream dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_fill(a_out_fill),
      .acc_count(a_acc), .neg_count(a_neg)
   );

   ext_stream #(.IN_WIDTH(16), .OUT_WIDTH(32), .CNT_WIDTH(16)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_fill(b_out_fill),
      .acc_count(b_acc), .neg_count(b_neg)
   );

   ext_stream #(.CNT_WIDTH(2)) dut_c (
      .clk(clk), .rst(rst),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_mode(c_in_mode),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_fill(c_out_fill),
      .acc_count(c_acc), .neg_count(c_neg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // one active edge, then settle at the following falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      chk("rst_in_ready",  32'(a_in_ready), 32'd1);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_data",  32'(a_out_data), 32'd0);
      chk("rst_acc",       32'(a_acc), 32'd0);
      chk("rst_neg",       32'(a_neg), 32'd0);
      rst = 1'b0;

      // basic extension, out_ready held high
      a_out_ready = 1;
      a_in_valid = 1; a_in_data = 8'h80; a_in_mode = 1;
      tick();
      chk("ext_80_s_valid", 32'(a_out_valid), 32'd1);
      chk("ext_80_s",       32'(a_out_data), 32'h0000FF80);
      chk("ext_80_s_fill",  32'(a_out_fill), 32'd1);
      a_in_data = 8'h80; a_in_mode = 0;
      tick();
      chk("ext_80_z",      32'(a_out_data), 32'h00000080);
      chk("ext_80_z_fill", 32'(a_out_fill), 32'd0);
      a_in_data = 8'h7F; a_in_mode = 1;
      tick();
      chk("ext_7f_s",      32'(a_out_data), 32'h0000007F);
      chk("ext_7f_s_fill", 32'(a_out_fill), 32'd0);
      a_in_valid = 0;
      tick();
      chk("drain_valid", 32'(a_out_valid), 32'd0);
      chk("basic_acc",   32'(a_acc), 32'd3);
      chk("basic_neg",   32'(a_neg), 32'd1);

      // backpressure: A1, A2 fill the buffer, A3 waits
      a_out_ready = 0;
      a_in_valid = 1; a_in_data = 8'h11; a_in_mode = 0;
      tick();
      chk("bp_ready_1", 32'(a_in_ready), 32'd1);
      a_in_data = 8'h22;
      tick();
      chk("bp_ready_full", 32'(a_in_ready), 32'd0);
      chk("bp_head_a1",    32'(a_out_data), 32'h00000011);
      a_in_data = 8'h33;
      tick();
      chk("bp_still_full", 32'(a_in_ready), 32'd0);
      chk("bp_acc_hold",   32'(a_acc), 32'd5);
      a_out_ready = 1;
      tick();
      chk("bp_head_a2",   32'(a_out_data), 32'h00000022);
      chk("bp_ready_back", 32'(a_in_ready), 32'd1);
      tick();
      chk("bp_head_a3", 32'(a_out_data), 32'h00000033);
      chk("bp_valid_a3", 32'(a_out_valid), 32'd1);
      a_in_valid = 0;
      tick();
      chk("bp_empty", 32'(a_out_valid), 32'd0);
      chk("bp_acc",   32'(a_acc), 32'd6);

      // asynchronous reset with two words buffered
      a_out_ready = 0;
      a_in_valid = 1; a_in_data = 8'hA5; a_in_mode = 1;
      tick();
      a_in_data = 8'h5A;
      tick();
      a_in_valid = 0;
      chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
      chk("pre_rst_ready", 32'(a_in_ready), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(a_out_valid), 32'd0);
      chk("arst_ready", 32'(a_in_ready), 32'd1);
      chk("arst_data",  32'(a_out_data), 32'd0);
      chk("arst_acc",   32'(a_acc), 32'd0);
      chk("arst_neg",   32'(a_neg), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // streaming at occupancy 1
      a_in_valid = 1; a_in_data = 8'h40; a_in_mode = 0;
      tick();
      a_out_ready = 1;
      a_in_data = 8'h41;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stream_data",  32'(a_out_data), 32'h41 + 32'(i));
         chk("stream_valid", 32'(a_out_valid), 32'd1);
         chk("stream_ready", 32'(a_in_ready), 32'd1);
         a_in_data = 8'(8'h42 + i);
      end
      a_in_valid = 0;
      chk("stream_acc", 32'(a_acc), 32'd11);
      tick();
      chk("stream_drain", 32'(a_out_valid), 32'd0);

      // 16 -> 32 instance
      b_out_ready = 1;
      b_in_valid = 1; b_in_data = 16'h8001; b_in_mode = 1;
      tick();
      chk("w32_s",      b_out_data, 32'hFFFF8001);
      chk("w32_s_fill", 32'(b_out_fill), 32'd1);
      b_in_mode = 0;
      tick();
      chk("w32_z",      b_out_data, 32'h00008001);
      chk("w32_z_fill", 32'(b_out_fill), 32'd0);
      b_in_valid = 0;

      // 2-bit counters saturate at 3
      c_out_ready = 1;
      c_in_valid = 1; c_in_data = 8'hF0; c_in_mode = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("sat_acc", 32'(c_acc), (i < 2) ? 32'(i + 1) : 32'd3);
         chk("sat_neg", 32'(c_neg), (i < 2) ? 32'(i + 1) : 32'd3);
      end
      chk("sat_data", 32'(c_out_data), 32'h0000FFF0);
      c_in_valid = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
